// File: rtl/shift_unit_pkg.sv
// Shared definitions for the bit-serial shift unit: opcodes (matching the ALU
// decoder's SHIFTER_control encoding), FSM state encodings and the default lui amount.
package shift_unit_pkg;

  typedef enum logic [2:0] {
    SH_NOP  = 3'b000,
    SH_LOAD = 3'b001,
    SH_SLL  = 3'b010,
    SH_SRL  = 3'b011,
    SH_SRA  = 3'b100,
    SH_ROR  = 3'b101,
    SH_ROL  = 3'b110
  } sh_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOADED = 2'b01,
    ST_SHIFT  = 2'b10,
    ST_DONE   = 2'b11
  } sh_state_e;

  localparam int LUI_SHIFT_DEF = 16;

endpackage

// File: rtl/shift_unit_step.sv
// One-bit combinational shift/rotate selected by the latched opcode.
// Rotates exist only when SHIFT_ROTATE_EN is defined; other codes pass data through.
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (op)
      SH_SLL: dout = {din[WIDTH-2:0], 1'b0};
      SH_SRL: dout = {1'b0, din[WIDTH-1:1]};
      SH_SRA: dout = {din[WIDTH-1], din[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
      SH_ROR: dout = {din[0], din[WIDTH-1:1]};
      SH_ROL: dout = {din[WIDTH-2:0], din[WIDTH-1]};
`endif
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Bit-serial shift register: loads an operand, then shifts one bit per clock.
// Optional serial rotates (ror/rol) are built when SHIFT_ROTATE_EN is defined.
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SHAMT_W   = 5,
  parameter int LUI_SHIFT = LUI_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         shift_ctrl,
  input  logic               m_shifter,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done
);

  sh_state_e          state_q, state_d;
  logic [2:0]         op_q;
  logic [SHAMT_W-1:0] count_q;
  logic [WIDTH-1:0]   step_out;
  logic               is_shift;
  logic               accept;

  always_comb begin
    is_shift = 1'b0;
    case (shift_ctrl)
      SH_SLL, SH_SRL, SH_SRA: is_shift = 1'b1;
`ifdef SHIFT_ROTATE_EN
      SH_ROR, SH_ROL:         is_shift = 1'b1;
`endif
      default:                is_shift = 1'b0;
    endcase
  end

  // Commands are taken in every state except SHIFT, including the zero-count
  // cycle where busy is low, so nothing slips in before done.
  assign accept = (state_q != ST_SHIFT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SHIFT: if (count_q <= SHAMT_W'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_LOADED;
      default:  state_d = state_q;
    endcase
    if (accept) begin
      if (shift_ctrl == SH_LOAD) state_d = ST_LOADED;
      else if (is_shift)         state_d = ST_SHIFT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= SH_NOP;
      count_q <= '0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_SHIFT) begin
        if (count_q != '0) begin
          result  <= step_out;
          count_q <= count_q - SHAMT_W'(1);
        end
      end else if (shift_ctrl == SH_LOAD) begin
        result <= m_shifter ? data_b : data_a;
      end else if (is_shift) begin
        op_q    <= shift_ctrl;
        count_q <= m_shifter ? SHAMT_W'(LUI_SHIFT) : shamt;
      end
    end
  end

  assign busy = (state_q == ST_SHIFT) && (count_q != '0);
  assign done = (state_q == ST_DONE);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op   (op_q),
    .din  (result),
    .dout (step_out)
  );

endmodule
